mem_stage_ctrl: RTL

Memory stage placed directly downstream of the EXE/MEM pipeline register. It consumes ALU_result (address), ST_value, MEM_R_en and MEM_W_en, and performs a multi-cycle access to an internal word-addressed data memory. It drives `ready` low while an access is in flight; the hazard/freeze logic uses `~ready` to stall every pipeline register upstream. MEM_result goes to the MEM/WB register.

---
 rtl/mem_stage_if.sv | 20 ++
 rtl/mem_stage_ctrl.sv | 111 +++++++++++
 2 files changed

// File: rtl/mem_stage_if.sv
// Pipeline-side bundle between the EXE/MEM register and the memory stage.
interface mem_stage_if;
    logic        MEM_R_en;
    logic        MEM_W_en;
    logic [31:0] ALU_result;
    logic [31:0] ST_value;
    logic [31:0] MEM_result;
    logic        ready;
    logic        addr_err;

    modport master (
        output MEM_R_en, MEM_W_en, ALU_result, ST_value,
        input  MEM_result, ready, addr_err
    );

    modport slave (
        input  MEM_R_en, MEM_W_en, ALU_result, ST_value,
        output MEM_result, ready, addr_err
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// Multi-cycle memory stage: captures a load/store, waits LATENCY cycles, then
// completes against an internal word-addressed data memory.
//
// state | meaning
// IDLE  | waiting for a request; ready = ~req
// WAIT  | access in flight, counting down; ready = 0
// DONE  | access completed this cycle; ready = 1, addr_err valid
module mem_stage_ctrl #(
    parameter int DEPTH     = 64,
    parameter int ADDR_BASE = 1024,
    parameter int LATENCY   = 3
) (
    input  logic        clk,
    input  logic        rst,
    mem_stage_if.slave  bus
);
    localparam int          AW   = $clog2(DEPTH);
    localparam int          CW   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [31:0] BASE = 32'(ADDR_BASE);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [31:0]   cap_addr;
    logic [31:0]   cap_data;
    logic          cap_wr;
    logic          cap_rd;
    logic [31:0]   mem_result_q;
    logic          addr_err_q;
    logic [31:0]   mem [DEPTH];

    logic          req;
    logic          finish;
    logic [31:0]   offset;
    logic          err;
    logic [AW-1:0] idx;

    assign req    = bus.MEM_R_en | bus.MEM_W_en;
    assign finish = (state == WAIT) && (cnt == '0);
    assign offset = cap_addr - BASE;
    assign err    = (cap_addr < BASE) || ((offset >> 2) >= 32'(DEPTH)) || (offset[1:0] != 2'b00);
    assign idx    = offset[AW+1:2];

    always_comb begin
        state_nxt = state;
        bus.ready = 1'b0;
        case (state)
            IDLE: begin
                bus.ready = ~req;
                if (req) state_nxt = WAIT;
            end
            WAIT: begin
                if (cnt == '0) state_nxt = DONE;
            end
            DONE: begin
                bus.ready = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Request capture and wait counter; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            cap_addr <= '0;
            cap_data <= '0;
            cap_wr   <= 1'b0;
            cap_rd   <= 1'b0;
        end else if (state == IDLE && req) begin
            cnt      <= CW'(LATENCY - 1);
            cap_addr <= bus.ALU_result;
            cap_data <= bus.ST_value;
            cap_wr   <= bus.MEM_W_en;
            cap_rd   <= bus.MEM_R_en & ~bus.MEM_W_en;
        end else if (state == WAIT && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Completion happens on the edge entering DONE; a write has priority over a read.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_result_q <= '0;
            addr_err_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (finish) begin
            addr_err_q <= err;
            if (cap_wr) begin
                if (!err) mem[idx] <= cap_data;
            end else if (cap_rd) begin
                mem_result_q <= err ? 32'h0 : mem[idx];
            end
        end else begin
            addr_err_q <= 1'b0;
        end
    end

    assign bus.MEM_result = mem_result_q;
    assign bus.addr_err   = addr_err_q;
endmodule
